// File: rtl/timer_clk_prescaler.sv
// MCLK-domain source select, edge qualification and two-stage pre-divider
// producing a one-cycle count-enable tick (plus a legacy-style toggle) for the timer core.
module timer_clk_prescaler #(
   parameter int NUM_SRC     = 4,
   parameter int SEL_W       = 2,
   parameter int ID_W        = 2,
   parameter int IDEX_W      = 3,
   parameter int SYNC_STAGES = 2
) (
   input  logic               MCLK,
   input  logic               reset,
   input  logic               clr,
   input  logic               run,
   input  logic [NUM_SRC-1:0] src_clk,
   input  logic [SEL_W-1:0]   sel,
   input  logic [1:0]         edge_mode,
   input  logic [ID_W-1:0]    id,
   input  logic [IDEX_W-1:0]  idex,
   output logic               tick,
   output logic               pre_tick,
   output logic               tick_toggle
);

   localparam int DIV_W = (1 << ID_W) - 1;

   typedef enum logic [1:0] {
      EDGE_RISE = 2'b00,
      EDGE_FALL = 2'b01,
      EDGE_BOTH = 2'b10,
      EDGE_NONE = 2'b11
   } edge_mode_t;

   logic [NUM_SRC-1:0] sync_q [SYNC_STAGES];
   logic [NUM_SRC-1:0] prev_q;
   logic [NUM_SRC-1:0] rise;
   logic [NUM_SRC-1:0] fall;
   logic               sel_rise;
   logic               sel_fall;
   logic               edge_hit;
   logic               ev;
   logic               s1;
   logic               s2;
   logic [DIV_W-1:0]   div_cnt;
   logic [DIV_W-1:0]   div_reload;
   logic [IDEX_W-1:0]  ex_cnt;

   // Every source keeps its own history so a sel change never fabricates an edge.
   always_ff @(posedge MCLK) begin
      if (reset) begin
         for (int i = 0; i < SYNC_STAGES; i++) begin
            sync_q[i] <= '0;
         end
         prev_q <= '0;
      end else begin
         sync_q[0] <= src_clk;
         for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_q[i] <= sync_q[i-1];
         end
         prev_q <= sync_q[SYNC_STAGES-1];
      end
   end

   assign rise = sync_q[SYNC_STAGES-1] & ~prev_q;
   assign fall = ~sync_q[SYNC_STAGES-1] & prev_q;

   // An out-of-range sel matches no source and therefore yields no events.
   always_comb begin
      sel_rise = 1'b0;
      sel_fall = 1'b0;
      for (int i = 0; i < NUM_SRC; i++) begin
         if (sel == SEL_W'(i)) begin
            sel_rise = rise[i];
            sel_fall = fall[i];
         end
      end
   end

   always_comb begin
      edge_hit = 1'b0;
      case (edge_mode_t'(edge_mode))
         EDGE_RISE: edge_hit = sel_rise;
         EDGE_FALL: edge_hit = sel_fall;
         EDGE_BOTH: edge_hit = sel_rise | sel_fall;
         default:   edge_hit = 1'b0;
      endcase
   end

   assign ev         = edge_hit & run;
   assign div_reload = DIV_W'((32'd1 << id) - 32'd1);
   assign s1         = ev && (div_cnt == '0);
   assign s2         = s1 && (ex_cnt == '0);

   // Divider state; id/idex are only looked at on reload so mid-period changes wait a period.
   always_ff @(posedge MCLK) begin
      if (reset || clr) begin
         div_cnt     <= div_reload;
         ex_cnt      <= idex;
         tick        <= 1'b0;
         pre_tick    <= 1'b0;
         tick_toggle <= 1'b0;
      end else begin
         pre_tick <= s1;
         tick     <= s2;
         if (s2) begin
            tick_toggle <= ~tick_toggle;
         end
         if (ev) begin
            div_cnt <= (div_cnt == '0) ? div_reload : div_cnt - 1'b1;
         end
         if (s1) begin
            ex_cnt <= (ex_cnt == '0) ? idex : ex_cnt - 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_timer_clk_prescaler.sv
// Bench for timer_clk_prescaler: directed scenarios plus randomized sources,
// every cycle compared against an edge-counting reference model.
module tb_timer_clk_prescaler;

   localparam int NUM_SRC     = 4;
   localparam int SEL_W       = 2;
   localparam int ID_W        = 2;
   localparam int IDEX_W      = 3;
   localparam int SYNC_STAGES = 2;

   logic               MCLK;
   logic               reset;
   logic               clr;
   logic               run;
   logic [NUM_SRC-1:0] src_clk;
   logic [SEL_W-1:0]   sel;
   logic [1:0]         edge_mode;
   logic [ID_W-1:0]    id;
   logic [IDEX_W-1:0]  idex;
   logic               tick;
   logic               pre_tick;
   logic               tick_toggle;

   logic [NUM_SRC-1:0] pipe [SYNC_STAGES+1];
   int                 e1_left;
   int                 e2_left;
   logic               exp_tick;
   logic               exp_pre;
   logic               exp_tog;
   int                 check_count;
   int                 error_count;
   int                 tick_seen;
   int                 pre_seen;
   int                 half_cnt [NUM_SRC];

   timer_clk_prescaler #(
      .NUM_SRC(NUM_SRC),
      .SEL_W(SEL_W),
      .ID_W(ID_W),
      .IDEX_W(IDEX_W),
      .SYNC_STAGES(SYNC_STAGES)
   ) dut (
      .MCLK(MCLK),
      .reset(reset),
      .clr(clr),
      .run(run),
      .src_clk(src_clk),
      .sel(sel),
      .edge_mode(edge_mode),
      .id(id),
      .idex(idex),
      .tick(tick),
      .pre_tick(pre_tick),
      .tick_toggle(tick_toggle)
   );

   initial begin
      MCLK = 1'b0;
      forever #5 MCLK = ~MCLK;
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      check_count++;
      if (observed !== expected) begin
         error_count++;
         $display("[TB] FAIL %s: got %0d expected %0d at %0t", tag, observed, expected, $time);
      end
   endtask

   // Model counts edges remaining until each terminal rather than tracking hardware counters.
   task automatic modelLoad();
      e1_left = 1 << id;
      e2_left = int'(idex) + 1;
   endtask

   task automatic modelStep();
      logic [NUM_SRC-1:0] cur;
      logic [NUM_SRC-1:0] old;
      logic               r;
      logic               f;
      logic               hit;
      if (reset) begin
         for (int k = 0; k <= SYNC_STAGES; k++) pipe[k] = '0;
         modelLoad();
         exp_tick = 1'b0;
         exp_pre  = 1'b0;
         exp_tog  = 1'b0;
      end else begin
         cur = pipe[SYNC_STAGES-1];
         old = pipe[SYNC_STAGES];
         hit = 1'b0;
         if (int'(sel) < NUM_SRC) begin
            r = cur[sel] & ~old[sel];
            f = ~cur[sel] & old[sel];
            case (edge_mode)
               2'b00:   hit = r;
               2'b01:   hit = f;
               2'b10:   hit = r | f;
               default: hit = 1'b0;
            endcase
         end
         for (int k = SYNC_STAGES; k > 0; k--) pipe[k] = pipe[k-1];
         pipe[0]  = src_clk;
         exp_tick = 1'b0;
         exp_pre  = 1'b0;
         if (clr) begin
            modelLoad();
            exp_tog = 1'b0;
         end else if (hit && run) begin
            e1_left--;
            if (e1_left == 0) begin
               exp_pre = 1'b1;
               e1_left = 1 << id;
               e2_left--;
               if (e2_left == 0) begin
                  exp_tick = 1'b1;
                  exp_tog  = ~exp_tog;
                  e2_left  = int'(idex) + 1;
               end
            end
         end
      end
   endtask

   task automatic applyStimulus();
      @(posedge MCLK);
      modelStep();
      @(negedge MCLK);
      checkOutput("tick", tick, exp_tick);
      checkOutput("pre_tick", pre_tick, exp_pre);
      checkOutput("tick_toggle", tick_toggle, exp_tog);
      if (tick) tick_seen++;
      if (pre_tick) pre_seen++;
   endtask

   task automatic srcPeriods(input int idx, input int n, input int half);
      for (int p = 0; p < n; p++) begin
         src_clk[idx] = 1'b1;
         repeat (half) applyStimulus();
         src_clk[idx] = 1'b0;
         repeat (half) applyStimulus();
      end
   endtask

   task automatic pulseClr();
      clr = 1'b1;
      applyStimulus();
      clr = 1'b0;
   endtask

   initial begin
      int tbase;
      int pbase;
      int first;
      check_count = 0;
      error_count = 0;
      tick_seen   = 0;
      pre_seen    = 0;
      reset       = 1'b1;
      clr         = 1'b0;
      run         = 1'b1;
      src_clk     = '0;
      sel         = 2'd1;
      edge_mode   = 2'b00;
      id          = '0;
      idex        = '0;
      for (int s = 0; s < NUM_SRC; s++) half_cnt[s] = 2;
      for (int k = 0; k <= SYNC_STAGES; k++) pipe[k] = '0;
      modelLoad();
      exp_tick = 1'b0;
      exp_pre  = 1'b0;
      exp_tog  = 1'b0;

      repeat (3) applyStimulus();
      checkOutput("reset_tick", tick, 0);
      checkOutput("reset_toggle", tick_toggle, 0);
      reset = 1'b0;
      repeat (2) applyStimulus();

      $display("[TB] divide-by-1, source at MCLK/8");
      tbase = tick_seen;
      first = 0;
      src_clk[1] = 1'b1;
      for (int c = 1; c <= 4; c++) begin
         applyStimulus();
         if (tick && first == 0) first = c;
      end
      src_clk[1] = 1'b0;
      repeat (4) applyStimulus();
      checkOutput("first_tick_latency", first, SYNC_STAGES + 1);
      srcPeriods(1, 5, 4);
      checkOutput("div1_ticks", tick_seen - tbase, 6);
      checkOutput("div1_toggle", tick_toggle, 0);

      $display("[TB] id=2 idex=4 over 40 rising edges");
      id   = 2'd2;
      idex = 3'd4;
      pulseClr();
      tbase = tick_seen;
      pbase = pre_seen;
      srcPeriods(1, 40, 2);
      checkOutput("div20_pre", pre_seen - pbase, 10);
      checkOutput("div20_ticks", tick_seen - tbase, 2);

      $display("[TB] both edges then no edges");
      edge_mode = 2'b10;
      id        = 2'd1;
      idex      = 3'd0;
      pulseClr();
      tbase = tick_seen;
      srcPeriods(1, 6, 4);
      checkOutput("both_ticks", tick_seen - tbase, 6);
      edge_mode = 2'b11;
      tbase = tick_seen;
      pbase = pre_seen;
      srcPeriods(1, 6, 4);
      checkOutput("none_ticks", tick_seen - tbase, 0);
      checkOutput("none_pre", pre_seen - pbase, 0);
      edge_mode = 2'b10;
      tbase = tick_seen;
      srcPeriods(1, 1, 4);
      checkOutput("none_held_count", tick_seen - tbase, 1);

      $display("[TB] id change mid-period");
      edge_mode = 2'b00;
      id        = 2'd3;
      idex      = 3'd0;
      pulseClr();
      pbase = pre_seen;
      srcPeriods(1, 2, 2);
      id = 2'd1;
      srcPeriods(1, 5, 2);
      checkOutput("idchg_before8", pre_seen - pbase, 0);
      srcPeriods(1, 1, 2);
      checkOutput("idchg_at8", pre_seen - pbase, 1);
      srcPeriods(1, 4, 2);
      checkOutput("idchg_after", pre_seen - pbase, 3);

      $display("[TB] sel switching between static sources");
      edge_mode  = 2'b11;
      src_clk[0] = 1'b1;
      src_clk[2] = 1'b0;
      sel        = 2'd0;
      repeat (5) applyStimulus();
      edge_mode = 2'b10;
      tbase = tick_seen;
      pbase = pre_seen;
      for (int i = 0; i < 40; i++) begin
         sel = ((i % 3) == 0) ? 2'd2 : ((i % 5) == 0 ? 2'd1 : 2'd0);
         applyStimulus();
      end
      checkOutput("selsw_ticks", tick_seen - tbase, 0);
      checkOutput("selsw_pre", pre_seen - pbase, 0);
      edge_mode  = 2'b11;
      src_clk[0] = 1'b0;
      sel        = 2'd1;
      repeat (5) applyStimulus();

      $display("[TB] clr coincident with an edge, then reset mid-period");
      edge_mode = 2'b00;
      id        = 2'd1;
      idex      = 3'd1;
      pulseClr();
      src_clk[1] = 1'b1;
      applyStimulus();
      applyStimulus();
      clr = 1'b1;
      applyStimulus();
      clr = 1'b0;
      checkOutput("clr_toggle", tick_toggle, 0);
      src_clk[1] = 1'b0;
      repeat (2) applyStimulus();
      tbase = tick_seen;
      srcPeriods(1, 3, 2);
      checkOutput("clr_edge_dropped", tick_seen - tbase, 0);
      srcPeriods(1, 1, 2);
      checkOutput("clr_next_tick", tick_seen - tbase, 1);
      srcPeriods(1, 3, 2);
      reset = 1'b1;
      applyStimulus();
      reset = 1'b0;
      checkOutput("rst_tick", tick, 0);
      checkOutput("rst_pre", pre_tick, 0);
      checkOutput("rst_toggle", tick_toggle, 0);
      repeat (2) applyStimulus();
      tbase = tick_seen;
      srcPeriods(1, 3, 2);
      checkOutput("rst_partial_dropped", tick_seen - tbase, 0);
      srcPeriods(1, 1, 2);
      checkOutput("rst_full_period", tick_seen - tbase, 1);

      $display("[TB] randomized sources and controls");
      for (int c = 0; c < 4000; c++) begin
         for (int s = 0; s < NUM_SRC; s++) begin
            if (half_cnt[s] <= 1) begin
               src_clk[s]  = ~src_clk[s];
               half_cnt[s] = int'($urandom_range(5, 2));
            end else begin
               half_cnt[s]--;
            end
         end
         if ($urandom_range(99, 0) < 8) sel = SEL_W'($urandom_range(NUM_SRC - 1, 0));
         if ($urandom_range(99, 0) < 4) edge_mode = 2'($urandom_range(3, 0));
         if ($urandom_range(99, 0) < 5) id = ID_W'($urandom_range(3, 0));
         if ($urandom_range(99, 0) < 5) idex = IDEX_W'($urandom_range(7, 0));
         run   = ($urandom_range(99, 0) < 90);
         clr   = ($urandom_range(199, 0) < 3);
         reset = ($urandom_range(999, 0) < 3);
         applyStimulus();
      end
      reset = 1'b0;
      clr   = 1'b0;

      $display("CHECKS %0d ERRORS %0d", check_count, error_count);
      $finish;
   end

endmodule

// File: doc/timer_clk_prescaler.md
Name: timer_clk_prescaler

Overview:
- Synchronous successor to the Timer_A source-select/pre-divider.
- Runs entirely on MCLK. It synchronises NUM_SRC asynchronous source clocks and selects one. It then divides qualifying edges by 2^id (stage 1) and by idex+1 (stage 2).
- Emits a one-MCLK-cycle count-enable pulse (tick) to the timer core, plus a toggling level (tick_toggle) equivalent to the legacy divided clock.
- Adds edge-mode selection, a run enable, glitch-free source switching and parametrised widths.

Parameters:
- NUM_SRC, 4, number of source clock inputs (>=2)
- SEL_W, 2, width of sel; must satisfy 2^SEL_W >= NUM_SRC
- ID_W, 2, width of id; stage-1 divide = 2^id, so the maximum is 2^(2^ID_W - 1)
- IDEX_W, 3, width of idex; stage-2 divide = idex+1
- SYNC_STAGES, 2, synchroniser depth per source (>=2)

Ports:
- MCLK  in  1  system clock; all flops rise on it
- reset  in  1  synchronous, active-high reset
- clr  in  1  synchronous logic clear (TACLR equivalent), active-high
- run  in  1  count enable; low freezes dividers
- src_clk  in  NUM_SRC  asynchronous source clock levels (TAxCLK, ACLK, SMCLK, INCLK order)
- sel  in  SEL_W  source index; an index >= NUM_SRC selects nothing (no events)
- edge_mode  in  2  00 rising, 01 falling, 10 both, 11 none
- id  in  ID_W  stage-1 divide exponent
- idex  in  IDEX_W  stage-2 divide minus 1
- tick  out  1  one-cycle pulse per divided period
- pre_tick  out  1  one-cycle pulse per stage-1 terminal count
- tick_toggle  out  1  inverts on every tick

Behaviour:
- Synchroniser:
  - Every source has its own SYNC_STAGES flop chain and its own previous-value flop. All of these update every cycle regardless of run, sel or clr.
  - Edge detection compares each source's synced value with that source's own previous value. Changing sel therefore never creates a spurious edge.
- Event:
  - ev = edge of the selected source qualified by edge_mode, AND run, AND (sel < NUM_SRC).
  - edge_mode 11 means ev is always 0.
- Stage 1 (div_cnt, ID_W-derived width):
  - On ev: if div_cnt==0, raise the stage-1 terminal (s1) and reload 2^id - 1 from the current id; otherwise decrement.
- Stage 2 (ex_cnt, IDEX_W bits):
  - On s1: if ex_cnt==0, raise the stage-2 terminal and reload from the current idex; otherwise decrement.
- Outputs:
  - pre_tick and tick are registered: high for exactly one cycle, in the cycle after the terminal event.
  - tick_toggle flips on the same edge at which tick rises.
- Latency (id=0, idex=0): source sampled high first at MCLK edge n means tick goes high at edge n+SYNC_STAGES and low at n+SYNC_STAGES+1. Larger dividers add no extra latency to the terminal edge.
- Config changes:
  - id and idex are sampled only at reload (terminal count), reset or clr. A mid-period change takes effect from the next period.
  - sel and edge_mode take effect immediately.
- run low: counters and tick_toggle hold, and tick/pre_tick are 0. Resuming continues from the held counts.
- clr:
  - Reloads div_cnt = 2^id - 1 and ex_cnt = idex from the current inputs.
  - Clears tick, pre_tick and tick_toggle.
  - Synchroniser and previous-value flops are untouched.
  - clr has priority over a coincident ev; that event is discarded.
- reset:
  - All synchroniser and previous-value flops go to 0.
  - Counters load from the current id/idex.
  - tick=0, pre_tick=0, tick_toggle=0.
  - reset has priority over clr and ev. Reset mid-period abandons the partial count.
  - A source that is high at reset release registers as a rising edge once it propagates (a 0 to 1 transition).
- Max rate: a source toggling faster than MCLK/2 is undersampled. No detection is required; the source must be at most MCLK/4 for guaranteed counting.
- Width rule: the stage-1 divide never wraps. id at its maximum gives 2^(2^ID_W - 1), e.g. 8 for ID_W=2.

Test Plan:
- sel=1, edge_mode=00, id=0, idex=0, source a square wave at MCLK/8 -> one tick per source period; first tick exactly SYNC_STAGES edges after the first high sample; tick_toggle period = 2 source periods.
- id=2, idex=4, rising mode, 40 source rising edges -> pre_tick every 4 edges (10 pulses); tick every 20 edges (2 pulses); ticks on edges 20 and 40.
- edge_mode=10, id=1, idex=0, 6 full source periods -> 12 edges give 6 ticks. Repeat with edge_mode=11 -> 0 ticks, counters unchanged.
- id=3 mid-count (div_cnt=5), change to id=1 -> the current period still completes at the 8th edge; subsequent periods are 2 edges.
- Switch sel between a held-high and a held-low source repeatedly, with run=1 -> no tick or pre_tick is ever produced.
- clr asserted on the same cycle as a qualifying edge with id=1, idex=1 -> that edge is not counted; the next tick arrives 4 edges after clr; tick_toggle=0 after clr. Repeat with reset mid-period -> all outputs 0 the next cycle.
